// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter with tick stepping, hold-to-repeat and
// one-cycle overflow/underflow/changed pulses.
module bcd_counter4 #(
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter bit          WRAP          = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       inc_tick,
  input  logic       dec_tick,
  input  logic       inc_hold,
  input  logic       dec_hold,
  input  logic       clr,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands,
  output logic       overflow,
  output logic       underflow,
  output logic       changed
);

  localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] DelayLast  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

  rep_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;  // 1 = up
  logic [15:0]     val_q, val_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            chg_q, chg_d;

  logic rep_step;
  logic inc_req, dec_req;
  logic at_max, at_min;
  logic hold_lost;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Abort repeat when the latched button drops, both are pressed, or on clear.
  assign hold_lost = clr || (inc_hold && dec_hold) || !(dir_q ? inc_hold : dec_hold);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    rep_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!clr && (inc_hold ^ dec_hold)) begin
          state_d = StDelay;
          cnt_d   = '0;
          dir_d   = inc_hold;
        end
      end
      StDelay: begin
        if (hold_lost) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DelayLast) begin
          rep_step = 1'b1;
          state_d  = StRepeat;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRepeat: begin
        if (hold_lost) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == PeriodLast) begin
          rep_step = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // A tick and a repeat step in the same direction collapse into one request.
  assign inc_req = inc_tick || (rep_step && dir_q);
  assign dec_req = dec_tick || (rep_step && !dir_q);
  assign at_max  = (val_q == 16'h9999);
  assign at_min  = (val_q == 16'h0000);

  always_comb begin
    val_d = val_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (clr) begin
      val_d = 16'h0000;
    end else if (inc_req && dec_req) begin
      val_d = val_q;
    end else if (inc_req) begin
      if (at_max) begin
        ovf_d = 1'b1;
        val_d = WRAP ? 16'h0000 : val_q;
      end else begin
        val_d = bcd_inc(val_q);
      end
    end else if (dec_req) begin
      if (at_min) begin
        unf_d = 1'b1;
        val_d = WRAP ? 16'h9999 : val_q;
      end else begin
        val_d = bcd_dec(val_q);
      end
    end
    chg_d = (val_d != val_q);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      val_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      val_q   <= val_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      chg_q   <= chg_d;
    end
  end

  assign units     = val_q[3:0];
  assign tens      = val_q[7:4];
  assign hundreds  = val_q[11:8];
  assign thousands = val_q[15:12];
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign changed   = chg_q;

`ifndef SYNTHESIS
  digits_in_range_a : assert property (@(posedge CLK) disable iff (!RESET)
    (units <= 4'd9) && (tens <= 4'd9) && (hundreds <= 4'd9) && (thousands <= 4'd9));
  no_dual_limit_a : assert property (@(posedge CLK) disable iff (!RESET)
    !(overflow && underflow));
`endif

endmodule

// File: tb/tb_bcd_counter4.sv
// Directed bench: a wrapping and a saturating instance share one stimulus stream.
module tb_bcd_counter4;

  logic CLK = 1'b0;
  logic RESET;
  logic inc_tick, dec_tick, inc_hold, dec_hold, clr;

  logic [3:0] u_w, t_w, h_w, k_w;
  logic       ovf_w, unf_w, chg_w;
  logic [3:0] u_s, t_s, h_s, k_s;
  logic       ovf_s, unf_s, chg_s;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bcd_counter4 #(.REPEAT_DELAY(10), .REPEAT_PERIOD(4), .WRAP(1'b1)) dut_w (
    .CLK(CLK), .RESET(RESET), .inc_tick(inc_tick), .dec_tick(dec_tick),
    .inc_hold(inc_hold), .dec_hold(dec_hold), .clr(clr),
    .units(u_w), .tens(t_w), .hundreds(h_w), .thousands(k_w),
    .overflow(ovf_w), .underflow(unf_w), .changed(chg_w)
  );

  bcd_counter4 #(.REPEAT_DELAY(10), .REPEAT_PERIOD(4), .WRAP(1'b0)) dut_s (
    .CLK(CLK), .RESET(RESET), .inc_tick(inc_tick), .dec_tick(dec_tick),
    .inc_hold(inc_hold), .dec_hold(dec_hold), .clr(clr),
    .units(u_s), .tens(t_s), .hundreds(h_s), .thousands(k_s),
    .overflow(ovf_s), .underflow(unf_s), .changed(chg_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value plus flags {overflow, underflow, changed} for both instances.
  task automatic check_all(input string tag, input logic [15:0] ev_w, input logic [2:0] ef_w,
                           input logic [15:0] ev_s, input logic [2:0] ef_s);
    check_eq({tag, " val_w"}, {16'h0, k_w, h_w, t_w, u_w}, {16'h0, ev_w});
    check_eq({tag, " flg_w"}, {29'h0, ovf_w, unf_w, chg_w}, {29'h0, ef_w});
    check_eq({tag, " val_s"}, {16'h0, k_s, h_s, t_s, u_s}, {16'h0, ev_s});
    check_eq({tag, " flg_s"}, {29'h0, ovf_s, unf_s, chg_s}, {29'h0, ef_s});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_inc(input int n);
    inc_tick = 1'b1;
    repeat (n) tick();
    inc_tick = 1'b0;
  endtask

  task automatic pulse_dec();
    dec_tick = 1'b1;
    tick();
    dec_tick = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; inc_tick = 1'b0; dec_tick = 1'b0;
    inc_hold = 1'b0; dec_hold = 1'b0; clr = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset", 16'h0000, 3'b000, 16'h0000, 3'b000);
    @(negedge CLK);
    RESET = 1'b1;
    tick();

    for (int i = 1; i <= 3; i++) begin
      pulse_inc(1);
      check_all("inc3", 16'(i), 3'b001, 16'(i), 3'b001);
    end
    tick();
    check_all("inc3 idle", 16'h0003, 3'b000, 16'h0003, 3'b000);

    pulse_clr();
    check_all("clr", 16'h0000, 3'b001, 16'h0000, 3'b001);
    pulse_clr();
    check_all("clr at 0", 16'h0000, 3'b000, 16'h0000, 3'b000);

    pulse_dec();
    check_all("dec at 0", 16'h9999, 3'b011, 16'h0000, 3'b010);
    tick();
    check_all("unf 1cyc", 16'h9999, 3'b000, 16'h0000, 3'b000);

    pulse_clr();
    check_all("clr 9999", 16'h0000, 3'b001, 16'h0000, 3'b000);
    pulse_inc(199);
    check_all("to 0199", 16'h0199, 3'b001, 16'h0199, 3'b001);
    pulse_inc(1);
    check_all("carry 0200", 16'h0200, 3'b001, 16'h0200, 3'b001);
    pulse_inc(9799);
    check_all("to 9999", 16'h9999, 3'b001, 16'h9999, 3'b001);
    pulse_inc(1);
    check_all("inc at max", 16'h0000, 3'b101, 16'h9999, 3'b100);
    tick();
    check_all("ovf 1cyc", 16'h0000, 3'b000, 16'h9999, 3'b000);

    pulse_clr();
    check_all("clr split", 16'h0000, 3'b000, 16'h0000, 3'b001);
    pulse_inc(100);
    pulse_dec();
    check_all("0100 dec", 16'h0099, 3'b001, 16'h0099, 3'b001);
    pulse_inc(901);
    check_all("to 1000", 16'h1000, 3'b001, 16'h1000, 3'b001);
    pulse_dec();
    check_all("borrow 0999", 16'h0999, 3'b001, 16'h0999, 3'b001);

    pulse_clr();
    pulse_inc(42);
    inc_tick = 1'b1; dec_tick = 1'b1;
    tick();
    inc_tick = 1'b0; dec_tick = 1'b0;
    check_all("cancel", 16'h0042, 3'b000, 16'h0042, 3'b000);
    clr = 1'b1; inc_tick = 1'b1;
    tick();
    clr = 1'b0; inc_tick = 1'b0;
    check_all("clr beats inc", 16'h0000, 3'b001, 16'h0000, 3'b001);
    tick();

    // Hold from 0000: steps expected on edges 11, 15, 19, 23, 27.
    inc_hold = 1'b1;
    begin
      logic [15:0] ev;
      logic        step;
      ev = 16'h0000;
      for (int e = 1; e <= 30; e++) begin
        tick();
        step = (e >= 11) && (((e - 11) % 4) == 0);
        if (step) ev = ev + 16'h1;
        check_all($sformatf("hold e%0d", e), ev, {2'b00, step}, ev, {2'b00, step});
      end
    end
    inc_hold = 1'b0;
    repeat (20) tick();
    check_all("hold release", 16'h0005, 3'b000, 16'h0005, 3'b000);

    pulse_clr();
    pulse_inc(52);
    inc_hold = 1'b1;
    repeat (27) tick();
    check_all("at 0057", 16'h0057, 3'b001, 16'h0057, 3'b001);
    tick();
    #2;
    RESET = 1'b0;
    #1;
    check_all("async rst", 16'h0000, 3'b000, 16'h0000, 3'b000);
    @(negedge CLK);
    RESET = 1'b1;
    // Tick at edge 5 steps during DELAY; tick at edge 11 merges with the repeat step.
    begin
      logic [15:0] ev;
      logic        step;
      for (int e = 1; e <= 15; e++) begin
        inc_tick = (e == 5) || (e == 11);
        tick();
        inc_tick = 1'b0;
        step = (e == 5) || (e == 11) || (e == 15);
        ev   = (e < 5) ? 16'h0000 : (e < 11) ? 16'h0001 : (e < 15) ? 16'h0002 : 16'h0003;
        check_all($sformatf("rerun e%0d", e), ev, {2'b00, step}, ev, {2'b00, step});
      end
    end
    inc_hold = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
